// File: rtl/mux_n_skid.sv
`default_nettype none
// ============================================================================
// Module      : mux_n_skid
// Description : N:1 datapath select feeding a 2-entry skid buffer with a
//               valid/ready handshake on both sides. An out-of-range select
//               produces the DEFVAL word tagged with an error bit and sets a
//               sticky error flag.
// Ports       : clk, reset (async, active-high)
//               d[N*WIDTH] / sel / in_valid / in_ready   - upstream side
//               out_data / out_err / out_valid / out_ready - downstream side
//               err_sticky / err_clr                       - error status
// Revision    : 1.0 - initial release
// ============================================================================
module mux_n_skid #(
    parameter int          WIDTH  = 32,
    parameter int          N      = 4,
    parameter int          SELW   = $clog2(N),
    parameter logic [31:0] DEFVAL = 32'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   d,
    input  logic [SELW-1:0]      sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err_sticky,
    input  logic                 err_clr
);

    // Occupancy encoding of the two-entry buffer.
    localparam logic [1:0] c_cnt_empty = 2'd0;
    localparam logic [1:0] c_cnt_one   = 2'd1;
    localparam logic [1:0] c_cnt_full  = 2'd2;

    // One extra bit so the comparison against N is exact even when N == 2**SELW.
    localparam logic [SELW:0] c_sel_limit = N[SELW:0];

    logic [1:0]       count_q,     count_d;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic             head_err_q,  head_err_d;
    logic [WIDTH-1:0] tail_data_q, tail_data_d;
    logic             tail_err_q,  tail_err_d;
    logic             err_sticky_q, err_sticky_d;

    logic [WIDTH-1:0] w_def;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_bad_sel;
    logic [WIDTH-1:0] w_new_data;
    logic             w_push;
    logic             w_pop;

    // DEFVAL is 32 bits wide; fit it to WIDTH by truncation or zero-extension.
    generate
        if (WIDTH <= 32) begin : g_def_narrow
            assign w_def = DEFVAL[WIDTH-1:0];
        end else begin : g_def_wide
            assign w_def = {{(WIDTH-32){1'b0}}, DEFVAL};
        end
    endgenerate

    // Explicit compare-per-lane mux: an out-of-range sel never indexes past d.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if ({1'b0, sel} == i[SELW:0]) begin
                w_sel_data = d[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_bad_sel  = ({1'b0, sel} >= c_sel_limit);
    assign w_new_data = w_bad_sel ? w_def : w_sel_data;

    // in_ready comes only from registered occupancy, never from out_ready.
    assign in_ready  = (count_q != c_cnt_full);
    assign out_valid = (count_q != c_cnt_empty);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_comb begin
        count_d     = count_q;
        head_data_d = head_data_q;
        head_err_d  = head_err_q;
        tail_data_d = tail_data_q;
        tail_err_d  = tail_err_q;
        case (count_q)
            c_cnt_empty: begin
                if (w_push) begin
                    head_data_d = w_new_data;
                    head_err_d  = w_bad_sel;
                    count_d     = c_cnt_one;
                end
            end
            c_cnt_one: begin
                if (w_push && w_pop) begin
                    // Head leaves and the new entry takes its place directly.
                    head_data_d = w_new_data;
                    head_err_d  = w_bad_sel;
                end else if (w_push) begin
                    tail_data_d = w_new_data;
                    tail_err_d  = w_bad_sel;
                    count_d     = c_cnt_full;
                end else if (w_pop) begin
                    // Head keeps the popped value; out_valid masks it.
                    count_d     = c_cnt_empty;
                end
            end
            c_cnt_full: begin
                // No push possible here since in_ready is low.
                if (w_pop) begin
                    head_data_d = tail_data_q;
                    head_err_d  = tail_err_q;
                    count_d     = c_cnt_one;
                end
            end
            default: begin
                count_d = c_cnt_empty;
            end
        endcase
    end

    // A bad push in the same cycle as a clear wins.
    assign err_sticky_d = (err_sticky_q & ~err_clr) | (w_push & w_bad_sel);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= c_cnt_empty;
            head_data_q  <= '0;
            head_err_q   <= 1'b0;
            tail_data_q  <= '0;
            tail_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            head_data_q  <= head_data_d;
            head_err_q   <= head_err_d;
            tail_data_q  <= tail_data_d;
            tail_err_q   <= tail_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign out_data   = head_data_q;
    assign out_err    = head_err_q;
    assign err_sticky = err_sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_n_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_n_skid
// Description : Self-checking bench for mux_n_skid. Instance A (N=4) runs a
//               vector table, an async-reset sequence and a random
//               valid/ready stream against a reference queue. Instance B
//               (N=3, DEFVAL=DEAD_BEEF) covers out-of-range selects and the
//               sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_n_skid;

    logic clk;
    logic reset;

    // Instance A: N=4
    logic [127:0] d_a;
    logic [1:0]   sel_a;
    logic         in_valid_a, in_ready_a, out_err_a, out_valid_a, out_ready_a;
    logic         err_sticky_a, err_clr_a;
    logic [31:0]  out_data_a;

    // Instance B: N=3, SELW=2
    logic [95:0]  d_b;
    logic [1:0]   sel_b;
    logic         in_valid_b, in_ready_b, out_err_b, out_valid_b, out_ready_b;
    logic         err_sticky_b, err_clr_b;
    logic [31:0]  out_data_b;

    int tests;
    int fails;

    mux_n_skid #(.WIDTH(32), .N(4), .SELW(2), .DEFVAL(32'h0)) u_dut_a (
        .clk(clk), .reset(reset), .d(d_a), .sel(sel_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_err(out_err_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .err_sticky(err_sticky_a), .err_clr(err_clr_a)
    );

    mux_n_skid #(.WIDTH(32), .N(3), .SELW(2), .DEFVAL(32'hDEAD_BEEF)) u_dut_b (
        .clk(clk), .reset(reset), .d(d_b), .sel(sel_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_err(out_err_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .err_sticky(err_sticky_b), .err_clr(err_clr_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        iv;
        logic [1:0]  sel;
        logic        ordy;
        logic        exp_ir;
        logic        exp_ov;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic iv, logic [1:0] sel, logic ordy,
                                logic exp_ir, logic exp_ov, logic [31:0] exp_data);
        vec_t v;
        v.iv = iv; v.sel = sel; v.ordy = ordy;
        v.exp_ir = exp_ir; v.exp_ov = exp_ov; v.exp_data = exp_data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle on instance B; outputs sampled 1 time unit after the edge.
    task automatic step_b(input logic iv, input logic [1:0] sel, input logic ordy, input logic clr);
        @(negedge clk);
        in_valid_b  = iv;
        sel_b       = sel;
        out_ready_b = ordy;
        err_clr_b   = clr;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] refq[$];
    int          m_count;
    int          xfers;
    int          cycles;
    logic        iv_r, or_r, push_r, pop_r;
    logic [1:0]  sel_r;

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        d_a = '0; sel_a = '0; in_valid_a = 1'b0; out_ready_a = 1'b0; err_clr_a = 1'b0;
        d_b = '0; sel_b = '0; in_valid_b = 1'b0; out_ready_b = 1'b0; err_clr_b = 1'b0;
        for (int i = 0; i < 4; i++) d_a[i*32 +: 32] = 32'hCAFE_0000 + i;
        for (int i = 0; i < 3; i++) d_b[i*32 +: 32] = 32'hB000_0000 + i;

        // ---------------- reset state ----------------
        #2 reset = 1'b1;
        #1;
        chk("rst_out_valid", {31'b0, out_valid_a}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready_a},  32'd1);
        chk("rst_out_data",  out_data_a,           32'd0);
        chk("rst_out_err",   {31'b0, out_err_a},   32'd0);
        chk("rst_sticky",    {31'b0, err_sticky_b}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- vector table on instance A ----------------
        // Single push then drain.
        vecs.push_back(mk(1, 2'd2, 1, 1, 1, 32'hCAFE_0002));
        vecs.push_back(mk(0, 2'd0, 1, 1, 0, 32'h0));
        // Backpressure: A and B accepted, C refused while full.
        vecs.push_back(mk(1, 2'd0, 0, 1, 1, 32'hCAFE_0000));
        vecs.push_back(mk(1, 2'd1, 0, 0, 1, 32'hCAFE_0000));
        vecs.push_back(mk(1, 2'd3, 0, 0, 1, 32'hCAFE_0000));
        vecs.push_back(mk(0, 2'd0, 1, 1, 1, 32'hCAFE_0001));
        vecs.push_back(mk(0, 2'd0, 1, 1, 0, 32'h0));
        // Streaming at full rate: count stays at 1, in_ready stays high.
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1, 2'(k % 4), 1, 1, 1, 32'hCAFE_0000 + (k % 4)));
        vecs.push_back(mk(0, 2'd0, 1, 1, 0, 32'h0));

        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid_a  = vecs[i].iv;
            sel_a       = vecs[i].sel;
            out_ready_a = vecs[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_in_ready", i),  {31'b0, in_ready_a},  {31'b0, vecs[i].exp_ir});
            chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid_a}, {31'b0, vecs[i].exp_ov});
            if (vecs[i].exp_ov) begin
                chk($sformatf("vec%0d_out_data", i), out_data_a, vecs[i].exp_data);
                chk($sformatf("vec%0d_out_err", i),  {31'b0, out_err_a}, 32'd0);
            end
        end
        @(negedge clk);
        in_valid_a = 1'b0;

        // ---------------- out-of-range select on instance B ----------------
        step_b(1, 2'd3, 0, 0);
        chk("bad_out_valid", {31'b0, out_valid_b}, 32'd1);
        chk("bad_out_data",  out_data_b,            32'hDEAD_BEEF);
        chk("bad_out_err",   {31'b0, out_err_b},    32'd1);
        chk("bad_sticky",    {31'b0, err_sticky_b}, 32'd1);
        step_b(0, 2'd0, 1, 1);
        chk("clr_sticky",    {31'b0, err_sticky_b}, 32'd0);
        chk("clr_out_valid", {31'b0, out_valid_b},  32'd0);
        step_b(1, 2'd3, 1, 1);
        chk("setwins_sticky", {31'b0, err_sticky_b}, 32'd1);
        chk("setwins_data",   out_data_b,            32'hDEAD_BEEF);
        step_b(1, 2'd1, 1, 0);
        chk("good_data",   out_data_b,            32'hB000_0001);
        chk("good_err",    {31'b0, out_err_b},    32'd0);
        chk("good_sticky", {31'b0, err_sticky_b}, 32'd1);
        step_b(0, 2'd0, 1, 0);
        chk("b_drain_valid", {31'b0, out_valid_b}, 32'd0);

        // ---------------- async reset with buffer full ----------------
        @(negedge clk);
        in_valid_a = 1'b1; sel_a = 2'd2; out_ready_a = 1'b0;
        @(negedge clk);
        sel_a = 2'd3;
        @(negedge clk);
        in_valid_a = 1'b0;
        chk("full_in_ready", {31'b0, in_ready_a}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", {31'b0, out_valid_a}, 32'd0);
        chk("arst_in_ready",  {31'b0, in_ready_a},  32'd1);
        @(negedge clk);
        reset = 1'b0;
        in_valid_a = 1'b1; sel_a = 2'd1;
        @(posedge clk);
        #1;
        chk("post_rst_data", out_data_a, 32'hCAFE_0001);
        @(negedge clk);
        in_valid_a = 1'b0; out_ready_a = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_drain", {31'b0, out_valid_a}, 32'd0);

        // ---------------- random valid/ready vs reference queue ----------------
        m_count = 0;
        xfers   = 0;
        cycles  = 0;
        refq.delete();
        while (xfers < 10000 && cycles < 60000) begin
            @(negedge clk);
            cycles++;
            chk("rnd_out_valid", {31'b0, out_valid_a}, {31'b0, (m_count != 0)});
            chk("rnd_in_ready",  {31'b0, in_ready_a},  {31'b0, (m_count < 2)});
            if (m_count != 0) begin
                chk("rnd_out_data", out_data_a, refq[0]);
            end
            iv_r  = ($urandom_range(3) != 0);
            or_r  = ($urandom_range(3) != 0);
            sel_r = 2'($urandom_range(3));
            for (int i = 0; i < 4; i++) d_a[i*32 +: 32] = $urandom;
            in_valid_a  = iv_r;
            sel_a       = sel_r;
            out_ready_a = or_r;
            push_r = iv_r && (m_count < 2);
            pop_r  = or_r && (m_count != 0);
            if (pop_r) begin
                void'(refq.pop_front());
                xfers++;
            end
            if (push_r) refq.push_back(d_a[sel_r*32 +: 32]);
            m_count = m_count + (push_r ? 1 : 0) - (pop_r ? 1 : 0);
        end
        if (xfers < 10000) begin
            tests++;
            fails++;
            $display("FAIL rnd_budget: got %0d transfers expected 10000", xfers);
        end
        @(negedge clk);
        in_valid_a = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
